// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: single-cycle mult/multu/mthi/mtlo, iterative
// restoring divider for div/divu, combinational low product for mul.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [1:0]       multiply,
    input  logic [1:0]       divide,
    input  logic [1:0]       HI_sel,
    input  logic [1:0]       LO_sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mul_lo,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] SEL_SRC = 2'b00;
    localparam logic [1:0] SEL_MUL = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;

    logic [PW-1:0]      op_a_ext;
    logic [PW-1:0]      op_b_ext;
    logic [PW-1:0]      prod;
    logic               accept;
    logic               b_zero;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;

    // Operand extension makes one 2W-bit multiplier serve signed and unsigned
    always_comb begin
        op_a_ext = multiply[0] ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        op_b_ext = multiply[0] ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        prod     = op_a_ext * op_b_ext;
    end

    // Low product bits are identical for signed and unsigned operands
    assign mul_lo = prod[WIDTH-1:0];

    // Accept qualification and restoring-divider step datapath
    always_comb begin
        accept    = issue && (state_q == ST_IDLE);
        b_zero    = (src_b == '0);
        a_neg     = divide[0] & src_a[WIDTH-1];
        b_neg     = divide[0] & src_b[WIDTH-1];
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        // difference always fits in WIDTH bits when rem_ge is set
        rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = 1'b0;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (divide[1]) begin
                        if (b_zero) begin
                            dbz_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            dvd_d   = a_neg ? -src_a : src_a;
                            dvs_d   = b_neg ? -src_b : src_b;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            rem_d   = '0;
                            count_d = '0;
                        end
                    end else if (multiply[1]) begin
                        if (HI_sel == SEL_MUL) hi_d = prod[PW-1:WIDTH];
                        if (LO_sel == SEL_MUL) lo_d = prod[WIDTH-1:0];
                    end else begin
                        if (HI_sel == SEL_SRC) hi_d = src_a;
                        if (LO_sel == SEL_SRC) lo_d = src_a;
                    end
                end
            end
            ST_RUN: begin
                rem_d   = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                dvd_d   = {dvd_q[WIDTH-2:0], rem_ge};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                lo_d    = qneg_q ? -dvd_q : dvd_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != ST_IDLE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares when a result is presented.
module tb_hilo_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         issue;
    logic [1:0]   multiply;
    logic [1:0]   divide;
    logic [1:0]   HI_sel;
    logic [1:0]   LO_sel;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] mul_lo;
    logic         busy;
    logic         div_by_zero;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .multiply    (multiply),
        .divide      (divide),
        .HI_sel      (HI_sel),
        .LO_sel      (LO_sel),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi          (hi),
        .lo          (lo),
        .mul_lo      (mul_lo),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic         is_div;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz, input logic eis_div);
        exp_t e;
        e.name = name; e.hi = ehi; e.lo = elo; e.dbz = edbz; e.is_div = eis_div;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] m, input logic [1:0] d, input logic [1:0] hs,
                         input logic [1:0] ls, input logic [W-1:0] a, input logic [W-1:0] b);
        issue = 1'b1; multiply = m; divide = d; HI_sel = hs; LO_sel = ls; src_a = a; src_b = b;
    endtask

    task automatic idle();
        issue = 1'b0; multiply = 2'b00; divide = 2'b00; HI_sel = 2'b11; LO_sel = 2'b11;
    endtask

    // Single-cycle op (or divide by zero): result checked by monitor next cycle
    task automatic one_op(input string name, input logic [1:0] m, input logic [1:0] d,
                          input logic [1:0] hs, input logic [1:0] ls,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
        push(name, ehi, elo, edbz, 1'b0);
        @(posedge clk); #1 drive(m, d, hs, ls, a, b);
        @(posedge clk); #1 idle();
        @(negedge clk);
    endtask

    task automatic wait_div(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (n >= 100) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic div_op(input string name, input logic [1:0] d,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo);
        push(name, ehi, elo, 1'b0, 1'b1);
        @(posedge clk); #1 drive(2'b00, d, 2'b10, 2'b10, a, b);
        @(posedge clk); #1 idle();
        wait_div(name);
    endtask

    // Monitor: predicts presentation from the inputs seen at the previous negedge
    initial begin : monitor
        logic pend, busy_prev, dbz_low;
        int   busy_cnt;
        exp_t e;
        pend = 1'b0; busy_prev = 1'b0; dbz_low = 1'b0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; busy_prev = 1'b0; dbz_low = 1'b0; busy_cnt = 0;
                continue;
            end
            if (dbz_low) begin
                chk("dbz_one_cycle", W'(div_by_zero), '0);
                dbz_low = 1'b0;
            end
            if (pend) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow_sync", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_kind"}, W'(e.is_div), '0);
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_busy"}, W'(busy), '0);
                    chk({e.name, "_dbz"}, W'(div_by_zero), W'(e.dbz));
                    if (e.dbz) dbz_low = 1'b1;
                end
            end
            if (busy) busy_cnt++;
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow_div", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_kind"}, W'(e.is_div), 32'd1);
                    chk({e.name, "_busy_len"}, W'(busy_cnt), 32'd33);
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
            pend = issue && !busy && (!divide[1] || (src_b == '0));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle();
        src_a = '0; src_b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_dbz", W'(div_by_zero), '0);
        @(posedge clk); #1 rst_n = 1'b1;

        one_op("mult", 2'b11, 2'b00, 2'b01, 2'b01, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        one_op("multu", 2'b10, 2'b00, 2'b01, 2'b01, 32'hFFFFFFFF, 32'd2,
               32'h00000001, 32'hFFFFFFFE, 1'b0);

        // mul encoding: only mul_lo is meaningful, HI/LO untouched
        push("mul", 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        @(posedge clk); #1 drive(2'b11, 2'b00, 2'b11, 2'b11, 32'd6, 32'd7);
        #4 chk("mul_lo", mul_lo, 32'd42);
        @(posedge clk); #1 idle();
        @(negedge clk);

        one_op("mthi", 2'b00, 2'b00, 2'b00, 2'b11, 32'h11, 32'd0, 32'h11, 32'hFFFFFFFE, 1'b0);
        one_op("mtlo", 2'b00, 2'b00, 2'b11, 2'b00, 32'h22, 32'd0, 32'h11, 32'h22, 1'b0);
        one_op("divu_zero", 2'b00, 2'b10, 2'b10, 2'b10, 32'hFFFFFFF9, 32'd0,
               32'h11, 32'h22, 1'b1);

        div_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        div_op("divu_big", 2'b10, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
        div_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        div_op("div_100_m7", 2'b11, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);

        // Ops issued while busy must be ignored entirely
        push("div_busy_ign", 32'd6, 32'h8E, 1'b0, 1'b1);
        @(posedge clk); #1 drive(2'b00, 2'b10, 2'b10, 2'b10, 32'd1000, 32'd7);
        @(posedge clk); #1 idle();
        repeat (3) @(posedge clk);
        #1 drive(2'b00, 2'b00, 2'b00, 2'b11, 32'hABCD, 32'd0);
        @(posedge clk); #1 drive(2'b11, 2'b00, 2'b01, 2'b01, 32'd3, 32'd3);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("busy_hold_hi", hi, 32'h00000002);
        chk("busy_hold_lo", lo, 32'hFFFFFFF2);
        wait_div("div_busy_ign");

        // Reset in the middle of a division aborts it
        @(posedge clk); #1 drive(2'b00, 2'b10, 2'b10, 2'b10, 32'd50, 32'd3);
        @(posedge clk); #1 idle();
        repeat (9) @(posedge clk);
        #2 chk("busy_before_rst", W'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        @(posedge clk); #3 rst_n = 1'b1;

        one_op("mtlo_after_rst", 2'b00, 2'b00, 2'b11, 2'b00, 32'd5, 32'd0, 32'd0, 32'd5, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
